ahb_wr_fifo_ctrl: RTL and testbench

AHB-Lite slave front-end for the AHB2AHB bridge source domain. It sequences the write side of the asynchronous bridge FIFO by capturing each AHB transfer and packing it into one command entry. It pushes that entry into the write-domain FIFO, stalling the bus with HREADYOUT while the FIFO is full. For reads it holds the bus until the returned data or error arrives from the read-return path.

---
 rtl/ahb_bridge_pkg.sv | 42 ++++
 rtl/ahb_addr_capture.sv | 39 +++
 rtl/ahb_wr_fifo_ctrl.sv | 146 ++++++++++++++
 tb/tb_ahb_wr_fifo_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared definitions for the AHB2AHB bridge source-domain write controller.
// Covers HTRANS codes, controller states, FIFO entry layout and transfer legality.
package ahb_bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StRdPush,
    StRdWait,
    StRdDone,
    StErr1,
    StErr2
  } state_e;

  // Entry field offsets for the default 32-bit address / 32-bit data layout.
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned ADDR_LSB = 32;
  localparam int unsigned SIZE_LSB = 64;
  localparam int unsigned WR_BIT   = 67;

  function automatic int unsigned d_size(int unsigned addr_w, int unsigned data_w);
    return 1 + 3 + addr_w + data_w;
  endfunction

  // Sizes above a word, and addresses not aligned to the size, are rejected.
  function automatic logic xfer_legal(logic [2:0] size, logic [1:0] addr_lo);
    logic ok;
    case (size)
      3'd0:    ok = 1'b1;
      3'd1:    ok = ~addr_lo[0];
      3'd2:    ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_addr_capture.sv
// Address-phase decode for the write controller: accept, legality, and the
// registered control fields used during the data phase.
module ahb_addr_capture
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hready,
  input  logic              take,
  output logic              accept,
  output logic              legal,
  output logic              hwrite_q,
  output logic [2:0]        hsize_q,
  output logic [ADDR_W-1:0] haddr_q
);

  assign accept = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign legal  = xfer_legal(hsize, haddr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      haddr_q  <= '0;
    end else if (take) begin
      hwrite_q <= hwrite;
      hsize_q  <= hsize;
      haddr_q  <= haddr;
    end
  end

endmodule

// File: rtl/ahb_wr_fifo_ctrl.sv
// AHB-Lite slave front-end that packs each transfer into one bridge FIFO entry,
// stalls on FIFO full and holds reads until the return path answers.
module ahb_wr_fifo_ctrl
  import ahb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned D_SIZE = d_size(ADDR_W, DATA_W)
) (
  input  logic              i_w_clk,
  input  logic              i_w_rst,
  input  logic              i_hsel,
  input  logic [1:0]        i_htrans,
  input  logic              i_hwrite,
  input  logic [2:0]        i_hsize,
  input  logic [ADDR_W-1:0] i_haddr,
  input  logic [DATA_W-1:0] i_hwdata,
  input  logic              i_hready,
  output logic              o_hreadyout,
  output logic              o_hresp,
  output logic [DATA_W-1:0] o_hrdata,
  input  logic              i_full,
  output logic              o_w_inc,
  output logic [D_SIZE-1:0] o_w_data,
  input  logic              i_rd_valid,
  input  logic              i_rd_err,
  input  logic [DATA_W-1:0] i_rd_data
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  state_e            state_q, state_d, addr_next;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              stale_q, stale_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic              accept, legal, can_take, take;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [ADDR_W-1:0] haddr_q;

  // A new address phase is only honoured in cycles where this slave drives ready.
  assign can_take = (state_q == StIdle) || (state_q == StRdDone) || (state_q == StErr2) ||
                    ((state_q == StWrData) && !i_full);
  assign take     = accept && can_take;

  ahb_addr_capture #(
    .ADDR_W(ADDR_W)
  ) u_addr_capture (
    .clk     (i_w_clk),
    .rst     (i_w_rst),
    .hsel    (i_hsel),
    .htrans  (i_htrans),
    .hwrite  (i_hwrite),
    .hsize   (i_hsize),
    .haddr   (i_haddr),
    .hready  (i_hready),
    .take    (take),
    .accept  (accept),
    .legal   (legal),
    .hwrite_q(hwrite_q),
    .hsize_q (hsize_q),
    .haddr_q (haddr_q)
  );

  always_comb begin
    if (!take)         addr_next = StIdle;
    else if (!legal)   addr_next = StErr1;
    else if (i_hwrite) addr_next = StWrData;
    else               addr_next = StRdPush;
  end

  assign cnt_inc  = (cnt_q == TimeoutCnt) ? cnt_q : cnt_q + CntW'(1);
  assign o_hrdata = hrdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stale_d     = stale_q;
    hrdata_d    = hrdata_q;
    o_hreadyout = 1'b1;
    o_hresp     = 1'b0;
    o_w_inc     = 1'b0;
    o_w_data    = '0;
    // The return path is in order: the first return after a timeout belongs to it.
    if (stale_q && i_rd_valid) stale_d = 1'b0;
    unique case (state_q)
      StIdle: state_d = addr_next;
      StWrData: begin
        o_hreadyout = !i_full;
        o_w_inc     = !i_full;
        o_w_data    = {hwrite_q, hsize_q, haddr_q, i_hwdata};
        if (!i_full) state_d = addr_next;
      end
      StRdPush: begin
        o_hreadyout = 1'b0;
        o_w_inc     = !i_full;
        o_w_data    = {hwrite_q, hsize_q, haddr_q, {DATA_W{1'b0}}};
        cnt_d       = '0;
        if (!i_full) state_d = StRdWait;
      end
      StRdWait: begin
        o_hreadyout = 1'b0;
        cnt_d       = cnt_inc;
        if (i_rd_valid && !stale_q) begin
          if (i_rd_err) begin
            state_d = StErr1;
          end else begin
            hrdata_d = i_rd_data;
            state_d  = StRdDone;
          end
        end else if (cnt_inc == TimeoutCnt) begin
          state_d = StErr1;
          stale_d = 1'b1;
        end
      end
      StRdDone: state_d = addr_next;
      StErr1: begin
        o_hreadyout = 1'b0;
        o_hresp     = 1'b1;
        state_d     = StErr2;
      end
      StErr2: begin
        o_hresp = 1'b1;
        state_d = addr_next;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_w_clk) begin
    if (i_w_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      stale_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stale_q  <= stale_d;
      hrdata_q <= hrdata_d;
    end
  end

endmodule

// File: tb/tb_ahb_wr_fifo_ctrl.sv
// Directed bench for ahb_wr_fifo_ctrl: stimulus queues expected pushes and
// responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_ahb_wr_fifo_ctrl;
  import ahb_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, full, rd_valid, rd_err;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, rd_data;
  logic        hready, hreadyout, hresp, w_inc;
  logic [31:0] hrdata;
  logic [67:0] w_data;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
    int          waits;
  } resp_t;

  logic [67:0] exp_push[$];
  resp_t       exp_resp[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mon_en   = 1'b0;
  logic        dphase   = 1'b0;
  logic        prev_err1 = 1'b0;
  int          waits    = 0;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_wr_fifo_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .i_w_clk    (clk),
    .i_w_rst    (rst),
    .i_hsel     (hsel),
    .i_htrans   (htrans),
    .i_hwrite   (hwrite),
    .i_hsize    (hsize),
    .i_haddr    (haddr),
    .i_hwdata   (hwdata),
    .i_hready   (hready),
    .o_hreadyout(hreadyout),
    .o_hresp    (hresp),
    .o_hrdata   (hrdata),
    .i_full     (full),
    .o_w_inc    (w_inc),
    .o_w_data   (w_data),
    .i_rd_valid (rd_valid),
    .i_rd_err   (rd_err),
    .i_rd_data  (rd_data)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] entry(logic wr, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
    return {wr, sz, a, d};
  endfunction

  // Monitor: push checks always on; response checks only when enabled.
  always @(negedge clk) begin
    if (w_inc) begin
      if (exp_push.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_push: got %h expected no push", w_data);
      end else begin
        chk("push_entry", 72'(w_data), 72'(exp_push.pop_front()));
      end
    end
    if (!mon_en) begin
      dphase = 1'b0;
    end else begin
      if (dphase) begin
        if (hreadyout) begin
          if (exp_resp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got hresp=%0b expected none", hresp);
          end else begin
            resp_t e;
            e = exp_resp.pop_front();
            chk("hresp", 72'(hresp), 72'(e.err));
            if (e.err) chk("err_first_cycle", 72'(prev_err1), 72'd1);
            if (e.chk_data) chk("hrdata", 72'(hrdata), 72'(e.data));
            chk("wait_states", 72'(waits), 72'(e.waits));
          end
          dphase = 1'b0;
        end else begin
          waits++;
        end
      end
      if (hsel && hready && htrans[1]) begin
        dphase = 1'b1;
        waits  = 0;
      end
    end
    prev_err1 = hresp && !hreadyout;
  end

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                            input logic [1:0] tr, input logic [31:0] wd);
    int   n = 0;
    logic r;
    hsel = 1'b1; htrans = tr; hwrite = wr; hsize = sz; haddr = a;
    do begin
      @(negedge clk);
      r = hready;
      @(posedge clk);
      n++;
    end while (!r && n < 200);
    if (!r) begin
      n_checks++;
      n_fail++;
      $display("FAIL addr_accept_timeout: got no ready expected ready within 200 cycles");
    end
    #1;
    if (wr) hwdata = wd;
    hsel = 1'b0; htrans = HTRANS_IDLE;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hready && n < 200);
    if (!hready) begin
      n_checks++;
      n_fail++;
      $display("FAIL data_phase_timeout: got no ready expected ready within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd_pulse(input int dly, input logic err, input logic [31:0] d);
    repeat (dly) @(posedge clk);
    #1;
    rd_valid = 1'b1; rd_err = err; rd_data = d;
    @(posedge clk);
    #1;
    rd_valid = 1'b0; rd_err = 1'b0;
  endtask

  task automatic exp_r(input logic err, input logic cd, input logic [31:0] d, input int w);
    resp_t e;
    e.err = err; e.chk_data = cd; e.data = d; e.waits = w;
    exp_resp.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = 3'd0;
    haddr = '0; hwdata = '0; full = 1'b0; rd_valid = 1'b0; rd_err = 1'b0; rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hreadyout", 72'(hreadyout), 72'd1);
    chk("rst_hresp", 72'(hresp), 72'd0);
    chk("rst_hrdata", 72'(hrdata), 72'd0);
    chk("rst_w_inc", 72'(w_inc), 72'd0);
    chk("rst_w_data", 72'(w_data), 72'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Single write, zero wait states.
    exp_push.push_back(entry(1'b1, 3'd2, 32'h1000, 32'hDEADBEEF));
    exp_r(1'b0, 1'b0, '0, 0);
    addr_phase(1'b1, 3'd2, 32'h1000, HTRANS_NONSEQ, 32'hDEADBEEF);
    wait_done();

    // Write stalled by a full FIFO for three cycles.
    exp_push.push_back(entry(1'b1, 3'd2, 32'h1004, 32'h0BADF00D));
    exp_r(1'b0, 1'b0, '0, 3);
    full = 1'b1;
    addr_phase(1'b1, 3'd2, 32'h1004, HTRANS_NONSEQ, 32'h0BADF00D);
    repeat (3) @(posedge clk);
    #1;
    full = 1'b0;
    wait_done();

    // Pipelined back-to-back writes.
    for (int i = 0; i < 3; i++) begin
      exp_push.push_back(entry(1'b1, 3'd2, 32'(4 * i), 32'h11111111 * (i + 1)));
      exp_r(1'b0, 1'b0, '0, 0);
    end
    addr_phase(1'b1, 3'd2, 32'h0, HTRANS_NONSEQ, 32'h11111111);
    addr_phase(1'b1, 3'd2, 32'h4, HTRANS_SEQ, 32'h22222222);
    addr_phase(1'b1, 3'd2, 32'h8, HTRANS_SEQ, 32'h33333333);
    wait_done();

    // Read with data returned in the sixth data-phase cycle.
    exp_push.push_back(entry(1'b0, 3'd2, 32'h2000, 32'h0));
    exp_r(1'b0, 1'b1, 32'h12345678, 6);
    addr_phase(1'b0, 3'd2, 32'h2000, HTRANS_NONSEQ, '0);
    rd_pulse(5, 1'b0, 32'h12345678);
    wait_done();

    // Read timeout: push, 8 wait cycles, then the two-cycle error.
    exp_push.push_back(entry(1'b0, 3'd2, 32'h2004, 32'h0));
    exp_r(1'b1, 1'b0, '0, 10);
    addr_phase(1'b0, 3'd2, 32'h2004, HTRANS_NONSEQ, '0);
    wait_done();

    // Late return from the timed-out read is dropped; the next read gets its own data.
    exp_push.push_back(entry(1'b0, 3'd1, 32'h3002, 32'h0));
    exp_r(1'b0, 1'b1, 32'hCAFEF00D, 6);
    addr_phase(1'b0, 3'd1, 32'h3002, HTRANS_NONSEQ, '0);
    rd_pulse(2, 1'b0, 32'hBAD0BAD0);
    rd_pulse(2, 1'b0, 32'hCAFEF00D);
    wait_done();

    // Illegal transfers: unaligned halfword and oversized transfer.
    exp_r(1'b1, 1'b0, '0, 1);
    addr_phase(1'b1, 3'd1, 32'h1001, HTRANS_NONSEQ, 32'h5555AAAA);
    wait_done();
    exp_r(1'b1, 1'b0, '0, 1);
    addr_phase(1'b0, 3'd3, 32'h1000, HTRANS_NONSEQ, '0);
    wait_done();

    // BUSY is ignored: no push, no response.
    hsel = 1'b1; htrans = HTRANS_BUSY; hwrite = 1'b1; haddr = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;

    // Read-return error.
    exp_push.push_back(entry(1'b0, 3'd0, 32'h4001, 32'h0));
    exp_r(1'b1, 1'b0, '0, 4);
    addr_phase(1'b0, 3'd0, 32'h4001, HTRANS_NONSEQ, '0);
    rd_pulse(2, 1'b1, 32'hFFFFFFFF);
    wait_done();

    // Reset while waiting for read data.
    mon_en = 1'b0;
    exp_push.push_back(entry(1'b0, 3'd2, 32'h5000, 32'h0));
    addr_phase(1'b0, 3'd2, 32'h5000, HTRANS_NONSEQ, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_wait_stall", 72'(hreadyout), 72'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_hreadyout", 72'(hreadyout), 72'd1);
    chk("mid_rst_hresp", 72'(hresp), 72'd0);
    chk("mid_rst_hrdata", 72'(hrdata), 72'd0);
    chk("mid_rst_w_inc", 72'(w_inc), 72'd0);
    chk("mid_rst_w_data", 72'(w_data), 72'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Recovery after reset.
    exp_push.push_back(entry(1'b1, 3'd0, 32'h0013, 32'hA5A5A5A5));
    exp_r(1'b0, 1'b0, '0, 0);
    addr_phase(1'b1, 3'd0, 32'h0013, HTRANS_NONSEQ, 32'hA5A5A5A5);
    wait_done();

    repeat (4) @(posedge clk);
    #1;
    chk("push_queue_drained", 72'(exp_push.size()), 72'd0);
    chk("resp_queue_drained", 72'(exp_resp.size()), 72'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
